sblk_act_feeder: RTL and testbench

SBLK_ACT_FEEDER -- requirements
Module: sblk_act_feeder

---
 rtl/sblk_pkg.sv | 19 +
 rtl/act_fifo.sv | 82 ++++++++
 rtl/sblk_act_feeder.sv | 191 +++++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// -----------------------------------------------------------------------------
// sblk_pkg
// Shared definitions for the superblock activation feeder: default parameter
// values and the feeder FSM state type.
// -----------------------------------------------------------------------------
package sblk_pkg;

    localparam int N_ROW_DEF      = 4;
    localparam int WID_ACT_DEF    = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WID_LEN_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/act_fifo.sv
// -----------------------------------------------------------------------------
// act_fifo
// First-word-fall-through buffer for one superblock row. The head word is
// always visible on rd_data while the buffer holds data; rd_data reads zero
// when the buffer is empty. Push and pop may happen in the same cycle.
//
// Ports:
//   clk_l    clock
//   rst_n    asynchronous active-low reset, empties the buffer
//   clear    synchronous flush of all contents
//   push     write wr_data (ignored when full)
//   wr_data  word to write
//   pop      drop the head word (ignored when empty)
//   rd_data  current head word, zero when empty
//   full     no free entry
//   empty    no stored entry
// -----------------------------------------------------------------------------
module act_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy bookkeeping; clear wins over any traffic.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only observed through the gated head below.
    always_ff @(posedge clk_l) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sblk_act_feeder.sv
// -----------------------------------------------------------------------------
// sblk_act_feeder
// Routes a burst of upstream activation words into per-row FWFT buffers that
// feed the superblock rows. Each row receives exactly burst_len words; words
// beyond that, or addressed to a nonexistent row, are accepted and discarded
// and raise a sticky err flag. A burst finishes once every row has handed
// burst_len words downstream.
//
// Ports:
//   clk_l            sole clock
//   rst_n            asynchronous active-low reset
//   start            one-cycle pulse that begins a burst (honoured in IDLE)
//   burst_len        words per row, sampled on an accepted start
//   src_data         upstream word
//   src_row          destination row of src_data
//   src_vld          upstream valid
//   src_rdy          upstream ready
//   act_data_in      row r head word at [r*2*WID_ACT +: 2*WID_ACT]
//   act_data_in_vld  per-row valid (row buffer not empty)
//   act_data_in_req  per-row ready from the superblock row
//   busy             burst in progress (RUN or DONE)
//   done             one-cycle completion pulse
//   err              sticky drop flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module sblk_act_feeder
    import sblk_pkg::*;
#(
    parameter int N_ROW      = N_ROW_DEF,
    parameter int WID_ACT    = WID_ACT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int WID_LEN    = WID_LEN_DEF
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WID_LEN-1:0]           burst_len,
    input  logic [2*WID_ACT-1:0]         src_data,
    input  logic [$clog2(N_ROW)-1:0]     src_row,
    input  logic                         src_vld,
    output logic                         src_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    input  logic [N_ROW-1:0]             act_data_in_req,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int ROW_W  = $clog2(N_ROW);
    localparam int WORD_W = 2 * WID_ACT;

    feeder_state_t        state;
    feeder_state_t        state_nxt;

    logic [WID_LEN-1:0]   len;
    logic [WID_LEN-1:0]   in_cnt  [N_ROW];
    logic [WID_LEN-1:0]   out_cnt [N_ROW];

    logic [N_ROW-1:0]     row_hit;
    logic [N_ROW-1:0]     fifo_full;
    logic [N_ROW-1:0]     fifo_empty;
    logic [N_ROW-1:0]     push;
    logic [N_ROW-1:0]     pop;

    logic                 start_acc;
    logic                 run;
    logic                 row_oob;
    logic                 sel_room;
    logic                 sel_at_len;
    logic                 drop;
    logic                 accept;
    logic                 all_out;

    // State register.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A zero-length burst sees all_out true immediately and
    // spends exactly one cycle in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)   state_nxt = ST_RUN;
            ST_RUN:  if (all_out) state_nxt = ST_DONE;
            ST_DONE:              state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs. Drop cases keep src_rdy high so the offending word is
    // swallowed instead of stalling the upstream.
    always_comb begin
        run     = (state == ST_RUN);
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        src_rdy = run && (sel_room || drop);
    end

    assign start_acc = (state == ST_IDLE) && start;

    // Decode the destination row and look up its counter and buffer status.
    // The padded compare catches row indices beyond N_ROW when N_ROW is not
    // a power of two.
    always_comb begin
        row_hit    = '0;
        sel_room   = 1'b0;
        sel_at_len = 1'b0;
        row_oob    = ({1'b0, src_row} >= (ROW_W+1)'(N_ROW));
        for (int r = 0; r < N_ROW; r++) begin
            row_hit[r] = !row_oob && (src_row == ROW_W'(r));
            if (row_hit[r]) begin
                sel_room   = (in_cnt[r] < len) && !fifo_full[r];
                sel_at_len = (in_cnt[r] == len);
            end
        end
    end

    assign drop   = row_oob || sel_at_len;
    assign accept = src_vld && src_rdy;

    // Per-row push/pop strobes and burst completion.
    always_comb begin
        all_out = 1'b1;
        for (int r = 0; r < N_ROW; r++) begin
            push[r] = accept && row_hit[r] && !drop;
            pop[r]  = act_data_in_vld[r] && act_data_in_req[r];
            if (out_cnt[r] != len) begin
                all_out = 1'b0;
            end
        end
    end

    // Burst length, per-row counters and the sticky error flag. Pushes are
    // gated by in_cnt < len and pops by stored data, so neither counter can
    // pass len.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            err <= 1'b0;
            for (int r = 0; r < N_ROW; r++) begin
                in_cnt[r]  <= '0;
                out_cnt[r] <= '0;
            end
        end else if (start_acc) begin
            len <= burst_len;
            err <= 1'b0;
            for (int r = 0; r < N_ROW; r++) begin
                in_cnt[r]  <= '0;
                out_cnt[r] <= '0;
            end
        end else begin
            if (accept && drop) begin
                err <= 1'b1;
            end
            for (int r = 0; r < N_ROW; r++) begin
                if (push[r]) begin
                    in_cnt[r] <= in_cnt[r] + 1'b1;
                end
                if (pop[r]) begin
                    out_cnt[r] <= out_cnt[r] + 1'b1;
                end
            end
        end
    end

    // Valid is the registered occupancy of each row buffer.
    assign act_data_in_vld = ~fifo_empty;

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        act_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_l   (clk_l),
            .rst_n   (rst_n),
            .clear   (start_acc),
            .push    (push[r]),
            .wr_data (src_data),
            .pop     (pop[r]),
            .rd_data (act_data_in[r*WORD_W +: WORD_W]),
            .full    (fifo_full[r]),
            .empty   (fifo_empty[r])
        );
    end

endmodule

// File: tb/tb_sblk_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_sblk_act_feeder
// Self-checking bench for sblk_act_feeder. A table of upstream words with
// expected ready/err behaviour drives the plain and drop bursts; hand-written
// sequences cover backpressure, zero-length bursts, out-of-range rows,
// start during RUN and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_sblk_act_feeder;

    localparam int N_ROW   = 4;
    localparam int WID_ACT = 16;
    localparam int WORD_W  = 2 * WID_ACT;
    localparam int WID_LEN = 8;

    logic                      clk_l = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      start = 1'b0;
    logic [WID_LEN-1:0]        burst_len = '0;
    logic [WORD_W-1:0]         src_data = '0;
    logic [1:0]                src_row = '0;
    logic                      src_vld = 1'b0;
    logic                      src_rdy;
    logic [WORD_W*N_ROW-1:0]   act_data_in;
    logic [N_ROW-1:0]          act_data_in_vld;
    logic [N_ROW-1:0]          act_data_in_req = '0;
    logic                      busy;
    logic                      done;
    logic                      err;

    // Three-row instance: with four rows a two-bit row index cannot name a
    // nonexistent row, so out-of-range routing is exercised here instead.
    logic                      b_start = 1'b0;
    logic [WID_LEN-1:0]        b_len = '0;
    logic [WORD_W-1:0]         b_src_data = '0;
    logic [1:0]                b_src_row = '0;
    logic                      b_src_vld = 1'b0;
    logic                      b_src_rdy;
    logic [WORD_W*3-1:0]       b_act;
    logic [2:0]                b_vld;
    logic [2:0]                b_req = 3'b111;
    logic                      b_busy;
    logic                      b_done;
    logic                      b_err;

    int tests_run    = 0;
    int tests_failed = 0;

    sblk_act_feeder u_dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .start           (start),
        .burst_len       (burst_len),
        .src_data        (src_data),
        .src_row         (src_row),
        .src_vld         (src_vld),
        .src_rdy         (src_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    sblk_act_feeder #(.N_ROW(3)) u_dut3 (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .start           (b_start),
        .burst_len       (b_len),
        .src_data        (b_src_data),
        .src_row         (b_src_row),
        .src_vld         (b_src_vld),
        .src_rdy         (b_src_rdy),
        .act_data_in     (b_act),
        .act_data_in_vld (b_vld),
        .act_data_in_req (b_req),
        .busy            (b_busy),
        .done            (b_done),
        .err             (b_err)
    );

    always #5 clk_l = ~clk_l;

    typedef struct {
        int          row;
        logic [31:0] data;
        logic        exp_rdy;
        logic        exp_err;
        logic        keep;
    } vec_t;

    vec_t vecs [21];

    // Downstream monitor state, sampled mid-cycle.
    logic [31:0]      rx_mem [N_ROW][16];
    int               rx_cnt [N_ROW];
    int               done_cnt  = 0;
    logic             vld_seen  = 1'b0;
    int               stab_err  = 0;
    logic [N_ROW-1:0] prev_hold = '0;
    logic [31:0]      prev_data [N_ROW];

    function automatic logic [31:0] rowData(input int r);
        return act_data_in[r*WORD_W +: WORD_W];
    endfunction

    // Records every downstream transfer, counts done pulses, and flags any
    // head word that changes while its row is stalled.
    always @(negedge clk_l) begin
        if (start && !busy) begin
            for (int r = 0; r < N_ROW; r++) rx_cnt[r] <= 0;
            done_cnt <= 0;
            vld_seen <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (|act_data_in_vld) vld_seen <= 1'b1;
            for (int r = 0; r < N_ROW; r++) begin
                if (act_data_in_vld[r] && act_data_in_req[r]) begin
                    rx_mem[r][rx_cnt[r] % 16] <= rowData(r);
                    rx_cnt[r] <= rx_cnt[r] + 1;
                end
            end
        end
        for (int r = 0; r < N_ROW; r++) begin
            if (prev_hold[r] && act_data_in_vld[r] && rowData(r) != prev_data[r])
                stab_err <= stab_err + 1;
            prev_hold[r] <= act_data_in_vld[r] && !act_data_in_req[r];
            prev_data[r] <= rowData(r);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic startBurst(input int len);
        start     = 1'b1;
        burst_len = WID_LEN'(len);
        @(posedge clk_l); #1;
        start     = 1'b0;
    endtask

    // Offers one word and waits (bounded) for it to be accepted.
    task automatic applyStimulus(input int row, input logic [31:0] data,
                                 output logic first_rdy, output logic accepted);
        src_row   = 2'(row);
        src_data  = data;
        src_vld   = 1'b1;
        accepted  = 1'b0;
        first_rdy = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_l);
            if (k == 0) first_rdy = src_rdy;
            if (src_rdy) accepted = 1'b1;
            @(posedge clk_l); #1;
            if (accepted) break;
        end
        src_vld = 1'b0;
    endtask

    task automatic sendWord(input string name, input int row, input logic [31:0] data);
        logic r0, acc;
        applyStimulus(row, data, r0, acc);
        checkOutput(name, acc, 1);
    endtask

    // Shows a word for one cycle and withdraws it before the edge.
    task automatic presentOnce(input int row, input logic [31:0] data, output logic rdy);
        src_row  = 2'(row);
        src_data = data;
        src_vld  = 1'b1;
        @(negedge clk_l);
        rdy      = src_rdy;
        src_vld  = 1'b0;
        @(posedge clk_l); #1;
    endtask

    task automatic waitDone(input string name);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_l); #1;
            if (done_cnt > 0) break;
        end
        repeat (3) begin @(posedge clk_l); #1; end
        checkOutput({name, "_done_pulses"}, done_cnt, 1);
        checkOutput({name, "_busy_after"}, busy, 0);
    endtask

    task automatic runTable(input int first, input int last);
        logic r0, acc;
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i].row, vecs[i].data, r0, acc);
            checkOutput($sformatf("vec%0d_rdy", i), r0, vecs[i].exp_rdy);
            checkOutput($sformatf("vec%0d_acc", i), acc, 1);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end
    endtask

    // Each row must have received its kept table words, in table order.
    task automatic checkRows(input int first, input int last);
        int n;
        for (int r = 0; r < N_ROW; r++) begin
            n = 0;
            for (int i = first; i <= last; i++) begin
                if (vecs[i].row == r && vecs[i].keep) begin
                    checkOutput($sformatf("row%0d_word%0d", r, n), rx_mem[r][n % 16], vecs[i].data);
                    n++;
                end
            end
            checkOutput($sformatf("row%0d_count", r), rx_cnt[r], n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic rdy;

        // Table: 12 round-robin words at len=3, then the len=2 drop burst.
        for (int i = 0; i < 12; i++)
            vecs[i] = '{row: i % 4, data: 32'hA000_0000 + i, exp_rdy: 1'b1, exp_err: 1'b0, keep: 1'b1};
        vecs[12] = '{1, 32'hC000_0010, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1, 32'hC000_0011, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1, 32'hC000_0012, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{0, 32'hC000_0000, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{0, 32'hC000_0001, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{2, 32'hC000_0020, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{2, 32'hC000_0021, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{3, 32'hC000_0030, 1'b1, 1'b1, 1'b1};
        vecs[20] = '{3, 32'hC000_0031, 1'b1, 1'b1, 1'b1};

        // Reset values.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk_l);
        #1;
        checkOutput("rst_vld", act_data_in_vld, 0);
        checkOutput("rst_data_lo", act_data_in[63:0], 0);
        checkOutput("rst_data_hi", act_data_in[127:64], 0);
        checkOutput("rst_rdy", src_rdy, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk_l); #1;

        // Plain burst, len=3, all rows ready.
        $display("[TB] burst len=3 round robin");
        act_data_in_req = 4'hF;
        startBurst(3);
        checkOutput("a_busy", busy, 1);
        runTable(0, 11);
        waitDone("a");
        checkRows(0, 11);
        checkOutput("a_err", err, 0);

        // Backpressure on row 2.
        $display("[TB] row 2 stalled, len=5");
        act_data_in_req = 4'b1011;
        startBurst(5);
        for (int k = 0; k < 4; k++) sendWord("b_row2_fill", 2, 32'hB002_0000 + k);
        checkOutput("b_vld2_full", act_data_in_vld[2], 1);
        checkOutput("b_head2", rowData(2), 32'hB002_0000);
        presentOnce(2, 32'hB002_0004, rdy);
        checkOutput("b_rdy_row2_full", rdy, 0);
        presentOnce(0, 32'hDEAD_0000, rdy);
        checkOutput("b_rdy_row0", rdy, 1);
        for (int k = 0; k < 5; k++) begin
            sendWord("b_row0", 0, 32'hB000_0000 + k);
            sendWord("b_row1", 1, 32'hB001_0000 + k);
            sendWord("b_row3", 3, 32'hB003_0000 + k);
        end
        checkOutput("b_head2_held", rowData(2), 32'hB002_0000);
        checkOutput("b_busy_stalled", busy, 1);
        act_data_in_req = 4'hF;
        sendWord("b_row2_last", 2, 32'hB002_0004);
        waitDone("b");
        for (int r = 0; r < N_ROW; r++) begin
            checkOutput($sformatf("b_row%0d_count", r), rx_cnt[r], 5);
            for (int k = 0; k < 5; k++)
                checkOutput($sformatf("b_row%0d_word%0d", r, k), rx_mem[r][k],
                            32'hB000_0000 + (r << 16) + k);
        end
        checkOutput("b_stable", stab_err, 0);

        // Over-length word on row 1, len=2.
        $display("[TB] drop of extra row-1 word");
        startBurst(2);
        runTable(12, 20);
        waitDone("c");
        checkRows(12, 20);
        checkOutput("c_err_sticky", err, 1);

        // Zero-length burst: RUN one cycle, DONE next, no traffic.
        $display("[TB] zero-length burst");
        startBurst(0);
        checkOutput("d_err_cleared", err, 0);
        checkOutput("d_busy_run", busy, 1);
        checkOutput("d_done_early", done, 0);
        @(posedge clk_l); #1;
        checkOutput("d_done_pulse", done, 1);
        @(posedge clk_l); #1;
        checkOutput("d_done_low", done, 0);
        checkOutput("d_busy_idle", busy, 0);
        checkOutput("d_done_count", done_cnt, 1);
        checkOutput("d_no_vld", vld_seen, 0);

        // Out-of-range row on the three-row instance.
        $display("[TB] out-of-range row");
        b_start = 1'b1;
        b_len   = 8'd1;
        @(posedge clk_l); #1;
        b_start = 1'b0;
        checkOutput("oob_busy", b_busy, 1);
        b_src_row  = 2'd3;
        b_src_data = 32'h0BAD_0003;
        b_src_vld  = 1'b1;
        @(negedge clk_l);
        checkOutput("oob_rdy", b_src_rdy, 1);
        @(posedge clk_l); #1;
        b_src_vld = 1'b0;
        checkOutput("oob_err", b_err, 1);
        checkOutput("oob_no_vld", b_vld, 0);

        // start during RUN is ignored.
        $display("[TB] start during RUN");
        startBurst(2);
        sendWord("e_row0a", 0, 32'hE000_0000);
        startBurst(7);
        checkOutput("e_busy", busy, 1);
        sendWord("e_row0b", 0, 32'hE000_0001);
        for (int r = 1; r < N_ROW; r++) begin
            sendWord("e_rowa", r, 32'hE000_0000 + (r << 16));
            sendWord("e_rowb", r, 32'hE000_0001 + (r << 16));
        end
        waitDone("e");
        for (int r = 0; r < N_ROW; r++)
            checkOutput($sformatf("e_row%0d_count", r), rx_cnt[r], 2);
        checkOutput("e_err", err, 0);

        // Reset mid-burst with buffers partly full.
        $display("[TB] reset mid-burst");
        act_data_in_req = 4'h0;
        startBurst(4);
        sendWord("f_row0a", 0, 32'hF000_0000);
        sendWord("f_row0b", 0, 32'hF000_0001);
        sendWord("f_row1", 1, 32'hF001_0000);
        checkOutput("f_vld_before", act_data_in_vld, 4'b0011);
        rst_n = 1'b0;
        #1;
        checkOutput("f_vld_rst", act_data_in_vld, 0);
        checkOutput("f_busy_rst", busy, 0);
        checkOutput("f_rdy_rst", src_rdy, 0);
        checkOutput("f_data_rst", act_data_in[63:0], 0);
        @(posedge clk_l); #1;
        rst_n = 1'b1;
        @(posedge clk_l); #1;
        startBurst(1);
        sendWord("f_new_row0", 0, 32'hF100_0000);
        checkOutput("f_latency_vld", act_data_in_vld, 4'b0001);
        checkOutput("f_latency_data", rowData(0), 32'hF100_0000);
        @(posedge clk_l); #1;
        checkOutput("f_hold_data", rowData(0), 32'hF100_0000);
        act_data_in_req = 4'hF;
        for (int r = 1; r < N_ROW; r++) sendWord("f_new_row", r, 32'hF100_0000 + (r << 16));
        waitDone("f");
        for (int r = 0; r < N_ROW; r++) begin
            checkOutput($sformatf("f_row%0d_count", r), rx_cnt[r], 1);
            checkOutput($sformatf("f_row%0d_word", r), rx_mem[r][0], 32'hF100_0000 + (r << 16));
        end
        checkOutput("f_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
